alu_muldiv: RTL
===============

ALU_MULDIV -- requirements
Module: alu_muldiv

Interface
REQ-001 Parameter XLEN, default 32, operand/result width in bits (legal: 8..64, even).
REQ-002 Parameter DIV_SIGNED_OVF_SAT, default 1; 1 = RISC-V overflow rule for signed divide (REQ-017), 0 = same rule (reserved for future use; must stay 1).
REQ-003 Ports: clk  input  1  rising-edge clock.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 in_valid  input  1  operation request valid.
REQ-006 in_ready  output  1  unit can accept a request this cycle.
REQ-007 a, b  input  XLEN each  operands, sampled on accept.
REQ-008 alu_ctrl  input  4  operation code, sampled on accept.
REQ-009 out_valid  output  1  result, zero and illegal are valid.
REQ-010 out_ready  input  1  consumer takes the result this cycle.
REQ-011 result  output  XLEN  registered result; zero  output  1  result == 0; illegal  output  1  unsupported code.

Function
REQ-012 Codes: 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0100 SLL, 0101 SRL, 1101 SRA, 0110 SUB, 0111 SLT, 1000 SLTU, 1001 MUL, 1010 MULHU, 1011 DIV, 1100 DIVU, 1110 REM, 1111 REMU.
REQ-013 Accept = in_valid & in_ready; FSM states IDLE, BUSY, DONE.
REQ-014 in_ready = (state==IDLE) | (state==DONE & out_ready); back-to-back single-cycle ops sustain one result per cycle.
REQ-015 Single-cycle ops (all non-M codes): accept in cycle N -> DONE, out_valid=1 in cycle N+1; ADD/SUB wrap modulo 2^XLEN; shifts use b[log2(XLEN)-1:0]; SLT signed, SLTU unsigned, result 0 or 1.
REQ-016 M ops: accept -> BUSY for exactly XLEN cycles (one shift-add or restoring-divide step per cycle) -> DONE; out_valid first asserted XLEN+1 cycles after accept; MUL = low XLEN bits, MULHU = high XLEN bits of unsigned 2*XLEN product.
REQ-017 Divide edge cases: b==0 -> DIV/DIVU quotient all-ones, REM/REMU = a; signed a==-2^(XLEN-1), b==-1 -> DIV = a, REM = 0; signed results take sign of quotient = a^b sign, remainder = sign of a.
REQ-018 DONE holds result, zero, illegal stable until out_ready; out_valid & out_ready with no new accept -> IDLE; with simultaneous accept -> next op proceeds as from IDLE.
REQ-019 In IDLE/BUSY, out_valid=0; inputs a, b, alu_ctrl ignored outside accept; in_valid during BUSY is not accepted (in_ready=0).
REQ-020 zero computed from the registered result, never from in-flight datapath values.

Reset
REQ-021 rst=1 at a clock edge -> state IDLE, out_valid=0, result=0, zero=1, illegal=0, iteration counter=0, regardless of state.
REQ-022 Reset during BUSY aborts the operation; no result for it is ever presented.
REQ-023 in_ready=1 in the first cycle after rst deasserts.

Configuration
REQ-024 Macro ALU_MULDIV_EN defined: REQ-016/017 behaviour, illegal always 0.
REQ-025 ALU_MULDIV_EN undefined: codes 1001,1010,1011,1100,1110,1111 complete in one cycle with result=0, zero=1, illegal=1; no multiply/divide hardware or BUSY state synthesised.

Structure
REQ-026 Shared package alu_pkg holds the 4-bit opcode constants, FSM state encoding, and helper is_muldiv(op) function; reused by decoder and testbench.
REQ-027 One sub-module muldiv_iter: iterative XLEN-step multiplier/restoring divider with start/done, instantiated only under ALU_MULDIV_EN; single-cycle ops stay in alu_muldiv.

Verification
REQ-028 XLEN=32, a=10,b=5, ADD then SUB then AND then OR back-to-back with out_ready=1 -> results 15,5,0,15 on 4 consecutive cycles, zero=1 only for AND.
REQ-029 SLT a=3,b=9 -> 1; SLT a=-1,b=1 -> 1; SLTU a=-1,b=1 -> 0; SUB a=42,b=42 -> result 0, zero=1.
REQ-030 MUL a=0x0001_0000,b=0x0001_0000 -> result 0, zero=1 exactly 33 cycles after accept; MULHU same operands -> 0x0000_0001.
REQ-031 DIV a=-7,b=2 -> -3; REM -> -1; DIVU a=7,b=0 -> 0xFFFF_FFFF; REMU -> 7; DIV a=0x8000_0000,b=-1 -> 0x8000_0000, REM -> 0.
REQ-032 out_ready held 0 for 5 cycles in DONE -> result stable, in_ready=0; rst asserted mid-BUSY (cycle 10 of a DIV) -> out_valid never rises, in_ready=1 next cycle after release.
REQ-033 ALU_MULDIV_EN undefined, MUL a=3,b=4 -> out_valid after 1 cycle, result 0, illegal=1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode, FSM-state and decode helpers for the ALU/mul-div unit and its bench.
package alu_pkg;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_XOR   = 4'b0011;
  localparam logic [3:0] OP_SLL   = 4'b0100;
  localparam logic [3:0] OP_SRL   = 4'b0101;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_SLTU  = 4'b1000;
  localparam logic [3:0] OP_MUL   = 4'b1001;
  localparam logic [3:0] OP_MULHU = 4'b1010;
  localparam logic [3:0] OP_DIV   = 4'b1011;
  localparam logic [3:0] OP_DIVU  = 4'b1100;
  localparam logic [3:0] OP_SRA   = 4'b1101;
  localparam logic [3:0] OP_REM   = 4'b1110;
  localparam logic [3:0] OP_REMU  = 4'b1111;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  function automatic logic is_muldiv(input logic [3:0] op);
    return op inside {OP_MUL, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative unit: XLEN-step unsigned shift-add multiplier / restoring divider with sign fix-up.
module muldiv_iter
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [3:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            done_o,
  output logic [XLEN-1:0] res_o
);

  localparam int unsigned CW = $clog2(XLEN);

  logic            active_q;
  logic [CW-1:0]   cnt_q;
  logic            div_q, rem_q, hi_q, negq_q, negr_q, bzero_q;
  logic [XLEN-1:0] acc_q, lo_q, opnd_q;
  logic [XLEN-1:0] acc_d, lo_d;
  logic [XLEN:0]   sum, shifted, diff;
  logic            sgn, is_div;
  logic [XLEN-1:0] a_mag, b_mag;

  assign sgn    = (op_i == OP_DIV) || (op_i == OP_REM);
  assign is_div = op_i inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  assign a_mag  = (sgn && a_i[XLEN-1]) ? -a_i : a_i;
  assign b_mag  = (sgn && b_i[XLEN-1]) ? -b_i : b_i;
  assign done_o = active_q && (cnt_q == CW'(XLEN - 1));

  // Divide-by-zero needs no special remainder path: the restoring steps leave |a| in acc.
  always_comb begin
    sum     = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    shifted = {acc_q, lo_q[XLEN-1]};
    diff    = shifted - {1'b0, opnd_q};
    if (div_q) begin
      acc_d = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
      lo_d  = {lo_q[XLEN-2:0], ~diff[XLEN]};
    end else begin
      acc_d = sum[XLEN:1];
      lo_d  = {sum[0], lo_q[XLEN-1:1]};
    end
    if (!div_q)       res_o = hi_q ? acc_d : lo_d;
    else if (rem_q)   res_o = negr_q ? -acc_d : acc_d;
    else if (bzero_q) res_o = '1;
    else              res_o = negq_q ? -lo_d : lo_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      active_q <= 1'b0;
      cnt_q    <= '0;
      div_q    <= 1'b0;
      rem_q    <= 1'b0;
      hi_q     <= 1'b0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      bzero_q  <= 1'b0;
      acc_q    <= '0;
      lo_q     <= '0;
      opnd_q   <= '0;
    end else if (start_i) begin
      active_q <= 1'b1;
      cnt_q    <= '0;
      div_q    <= is_div;
      rem_q    <= (op_i == OP_REM) || (op_i == OP_REMU);
      hi_q     <= (op_i == OP_MULHU);
      negq_q   <= sgn && (a_i[XLEN-1] ^ b_i[XLEN-1]);
      negr_q   <= sgn && a_i[XLEN-1];
      bzero_q  <= (b_i == '0);
      acc_q    <= '0;
      lo_q     <= is_div ? a_mag : a_i;
      opnd_q   <= is_div ? b_mag : b_i;
    end else if (active_q) begin
      acc_q <= acc_d;
      lo_q  <= lo_d;
      cnt_q <= cnt_q + 1'b1;
      if (done_o) active_q <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_muldiv.sv
// ALU with valid/ready handshake and optional iterative M-extension (enable with macro ALU_MULDIV_EN).
module alu_muldiv
  import alu_pkg::*;
#(
  parameter int unsigned XLEN               = 32,
  parameter int unsigned DIV_SIGNED_OVF_SAT = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [3:0]      alu_ctrl,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal
);

  localparam int unsigned SHW = $clog2(XLEN);

  if (DIV_SIGNED_OVF_SAT != 1) begin : g_cfg_check
    $error("alu_muldiv: DIV_SIGNED_OVF_SAT is reserved and must be 1");
  end

  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] result_q, result_d, alu_res;
  logic            illegal_q, illegal_d;
  logic [SHW-1:0]  shamt;
  logic            accept;

  assign shamt     = b[SHW-1:0];
  assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == ST_DONE);
  assign result    = result_q;
  assign zero      = (result_q == '0);
  assign illegal   = illegal_q;

`ifdef ALU_MULDIV_EN
  logic            md_start, md_done;
  logic [XLEN-1:0] md_res;

  muldiv_iter #(.XLEN(XLEN)) u_muldiv (
    .clk    (clk),
    .rst    (rst),
    .start_i(md_start),
    .op_i   (alu_ctrl),
    .a_i    (a),
    .b_i    (b),
    .done_o (md_done),
    .res_o  (md_res)
  );
`endif

  always_comb begin
    alu_res = '0;
    case (alu_ctrl)
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      OP_ADD:  alu_res = a + b;
      OP_SUB:  alu_res = a - b;
      OP_SLL:  alu_res = a << shamt;
      OP_SRL:  alu_res = a >> shamt;
      OP_SRA:  alu_res = XLEN'($signed(a) >>> shamt);
      OP_SLT:  alu_res[0] = $signed(a) < $signed(b);
      OP_SLTU: alu_res[0] = a < b;
      default: alu_res = '0;
    endcase
  end

  // An accept in DONE takes priority over the return to IDLE, giving back-to-back throughput.
  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    illegal_d = illegal_q;
`ifdef ALU_MULDIV_EN
    md_start  = 1'b0;
`endif
    if (accept) begin
      if (is_muldiv(alu_ctrl)) begin
`ifdef ALU_MULDIV_EN
        state_d  = ST_BUSY;
        md_start = 1'b1;
`else
        state_d   = ST_DONE;
        result_d  = '0;
        illegal_d = 1'b1;
`endif
      end else begin
        state_d   = ST_DONE;
        result_d  = alu_res;
        illegal_d = 1'b0;
      end
    end else if ((state_q == ST_DONE) && out_ready) begin
      state_d = ST_IDLE;
    end
`ifdef ALU_MULDIV_EN
    else if ((state_q == ST_BUSY) && md_done) begin
      state_d   = ST_DONE;
      result_d  = md_res;
      illegal_d = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      result_q  <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      illegal_q <= illegal_d;
    end
  end

endmodule
